// File: rtl/button_step_conditioner.sv
// button_step_conditioner: turns the raw, bouncy duty-cycle step switches
// into debounced levels and single-cycle duty_inc/duty_dec step pulses.
// Optional auto-repeat while a button is held: define BTN_AUTOREPEAT_EN.
module button_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swt_increase,
    input  logic       swt_decrease,
    output logic       duty_inc,
    output logic       duty_dec,
    output logic [1:0] btn_level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Channel 0 = increase, channel 1 = decrease throughout.
    logic [1:0]       sw_raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [1:0]       deb_nxt;
    logic [CNT_W-1:0] db_cnt     [2];
    logic [CNT_W-1:0] db_cnt_nxt [2];
    logic [1:0]       press;
    logic [1:0]       pulse_nxt;

    assign sw_raw    = {swt_decrease, swt_increase};
    assign btn_level = deb;

    // Debounce: accept s2 once it has differed from the debounced level for DEBOUNCE_CYCLES edges.
    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            deb_nxt[ch]    = deb[ch];
            db_cnt_nxt[ch] = '0;
            if (s2[ch] != deb[ch]) begin
                if (db_cnt[ch] == DB_LAST) begin
                    deb_nxt[ch] = s2[ch];
                end else if (db_cnt[ch] != CNT_MAX) begin
                    db_cnt_nxt[ch] = db_cnt[ch] + 1'b1;
                end else begin
                    db_cnt_nxt[ch] = db_cnt[ch];
                end
            end
        end
    end

    // A press is a debounced rise while the other channel is released; simultaneous rises cancel.
    assign press = deb & ~deb_q & {~deb[0], ~deb[1]};

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_RATE
    } rep_state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    rep_state_t       rep_st      [2];
    rep_state_t       rep_st_nxt  [2];
    logic [CNT_W-1:0] rep_cnt     [2];
    logic [CNT_W-1:0] rep_cnt_nxt [2];
    logic [1:0]       rep_fire;
    logic [1:0]       rep_ok;

    // Repeats are qualified on the post-edge levels so the first released cycle carries no pulse.
    assign rep_ok = deb_nxt & {~deb_nxt[0], ~deb_nxt[1]};

    // Per-channel repeat sequencer: delay phase after the press, then fixed-rate phase.
    always_comb begin
        rep_fire = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            rep_st_nxt[ch]  = rep_st[ch];
            rep_cnt_nxt[ch] = rep_cnt[ch];
            if (press[ch]) begin
                rep_st_nxt[ch]  = REP_DELAY;
                rep_cnt_nxt[ch] = '0;
            end else if (rep_st[ch] == REP_IDLE || !rep_ok[ch]) begin
                rep_st_nxt[ch]  = REP_IDLE;
                rep_cnt_nxt[ch] = '0;
            end else if (rep_cnt[ch] == ((rep_st[ch] == REP_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                rep_fire[ch]    = 1'b1;
                rep_st_nxt[ch]  = REP_RATE;
                rep_cnt_nxt[ch] = '0;
            end else if (rep_cnt[ch] != CNT_MAX) begin
                rep_cnt_nxt[ch] = rep_cnt[ch] + 1'b1;
            end
        end
    end

    // Repeat state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_st[0]  <= REP_IDLE;
            rep_st[1]  <= REP_IDLE;
            rep_cnt[0] <= '0;
            rep_cnt[1] <= '0;
        end else begin
            rep_st[0]  <= rep_st_nxt[0];
            rep_st[1]  <= rep_st_nxt[1];
            rep_cnt[0] <= rep_cnt_nxt[0];
            rep_cnt[1] <= rep_cnt_nxt[1];
        end
    end

    assign pulse_nxt = press | rep_fire;
`else
    assign pulse_nxt = press;
`endif

    // Synchroniser, debounce state and registered step pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            deb       <= '0;
            deb_q     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            duty_inc  <= 1'b0;
            duty_dec  <= 1'b0;
        end else begin
            s1        <= sw_raw;
            s2        <= s1;
            deb       <= deb_nxt;
            deb_q     <= deb;
            db_cnt[0] <= db_cnt_nxt[0];
            db_cnt[1] <= db_cnt_nxt[1];
            duty_inc  <= pulse_nxt[0];
            duty_dec  <= pulse_nxt[1];
        end
    end

endmodule
